// File: rtl/divisor_dcm_pkg.sv
// divisor_dcm_pkg: shared limits, counter widths and helpers for the DCM stand-in.
// No ports; imported by divisor_dcm and dcm_lock_ctr.
package divisor_dcm_pkg;

  localparam int unsigned DIV_MIN  = 2;
  localparam int unsigned DIV_MAX  = 256;
  localparam int unsigned LOCK_W   = 16;
  localparam int unsigned LOCK_MAX = 65535;

  // Phase generator: idle while unlocked, running once the first locked edge is seen.
  typedef enum logic {
    PH_IDLE = 1'b0,
    PH_RUN  = 1'b1
  } phase_state_e;

  // Number of input periods the registered phase output stays high: ceil(n/2).
  function automatic int unsigned half_ceil(input int unsigned n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/dcm_lock_ctr.sv
// dcm_lock_ctr: counts clk_i rising edges after reset release and asserts locked_o
// on the LOCK_CYCLES-th edge; locked_o then holds until the next reset.
// Ports:
//   clk_i     in  reference clock
//   rst_n_i   in  asynchronous active-low reset
//   locked_o  out lock indication (registered)
module dcm_lock_ctr
  import divisor_dcm_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic locked_o
);

  if ((LOCK_CYCLES < 1) || (LOCK_CYCLES > LOCK_MAX)) begin : g_bad_lock
    $error("dcm_lock_ctr: LOCK_CYCLES out of range 1..65535");
  end

  logic [LOCK_W-1:0] cnt_q, cnt_d;
  logic              locked_q, locked_d;

  // Count until the target edge, then freeze so the counter can never wrap.
  always_comb begin
    cnt_d    = cnt_q;
    locked_d = locked_q;
    if (!locked_q) begin
      cnt_d = cnt_q + LOCK_W'(1);
      if (cnt_d == LOCK_W'(LOCK_CYCLES)) begin
        locked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked_o = locked_q;

endmodule

// File: rtl/divisor_dcm.sv
// divisor_dcm: clock-divider stand-in for a clocking-wizard DCM.
// CLK_OUT1 = CLK_IN1 / DIVIDE at 50% duty, enabled once LOCKED asserts.
// Ports:
//   CLK_IN1   in  reference clock (only clock)
//   RESET     in  asynchronous active-low reset
//   CLK_OUT1  out divided clock, glitch free
//   LOCKED    out high once CLK_OUT1 is valid
module divisor_dcm
  import divisor_dcm_pkg::*;
#(
  parameter int unsigned DIVIDE      = 2,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic CLK_IN1,
  input  logic RESET,
  output logic CLK_OUT1,
  output logic LOCKED
);

  if ((DIVIDE < DIV_MIN) || (DIVIDE > DIV_MAX)) begin : g_bad_div
    $error("divisor_dcm: DIVIDE out of range 2..256");
  end

  localparam int unsigned CNT_W = ($clog2(DIVIDE) > 0) ? $clog2(DIVIDE) : 1;
  localparam int unsigned HALF  = half_ceil(DIVIDE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDE - 1);

  logic locked;

  dcm_lock_ctr #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lock (
    .clk_i   (CLK_IN1),
    .rst_n_i (RESET),
    .locked_o(locked)
  );

  assign LOCKED = locked;

  phase_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_p_q, out_p_d;

  // Phase generator. The first locked edge holds cnt at 0 and raises out_p, so the
  // first output rising edge lands exactly one input period after LOCKED.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_p_d = out_p_q;
    case (state_q)
      PH_IDLE: begin
        cnt_d   = '0;
        out_p_d = 1'b0;
        if (locked) begin
          state_d = PH_RUN;
          out_p_d = 1'b1;
        end
      end
      PH_RUN: begin
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        out_p_d = (32'(cnt_d) < HALF);
      end
      default: begin
        state_d = PH_IDLE;
        cnt_d   = '0;
        out_p_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_IN1 or negedge RESET) begin
    if (!RESET) begin
      state_q <= PH_IDLE;
      cnt_q   <= '0;
      out_p_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_p_q <= out_p_d;
    end
  end

  if ((DIVIDE % 2) == 1) begin : g_odd
    // out_p is high ceil(D/2) periods; ANDing with its half-period-delayed copy trims
    // the high time to D/2 periods. Only one AND input changes at a time, so no glitch.
    logic out_n_q;

    always_ff @(negedge CLK_IN1 or negedge RESET) begin
      if (!RESET) begin
        out_n_q <= 1'b0;
      end else begin
        out_n_q <= out_p_q;
      end
    end

    assign CLK_OUT1 = out_p_q & out_n_q;
  end else begin : g_even
    assign CLK_OUT1 = out_p_q;
  end

endmodule

// File: tb/tb_divisor_dcm.sv
// tb_divisor_dcm: several divisor_dcm instances share one 20-unit reference clock.
// Expected edge times of CLK_OUT1 and LOCKED are computed from the reset schedule and
// pushed into per-instance queues; monitors pop and compare on every output change.
module tb_divisor_dcm;

  localparam int NDUT = 6;
  localparam int unsigned DIV_T [NDUT] = '{2, 4, 3, 256, 5, 2};
  localparam int unsigned LCK_T [NDUT] = '{16, 16, 16, 1, 3, 16};
  localparam longint HP    = 10;
  localparam longint T_END = 25005;

  typedef struct {
    logic   val;
    longint t;
  } ev_t;

  ev_t clk_q [NDUT][$];
  ev_t lck_q [NDUT][$];

  longint sch_t [$];
  int     sch_i [$];
  logic   sch_v [$];

  logic            clk;
  logic [NDUT-1:0] rst;
  wire  [NDUT-1:0] dout;
  wire  [NDUT-1:0] dlock;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic push_ev(input int i, input bit is_lock, input logic v, input longint t);
    ev_t e;
    e.val = v;
    e.t   = t;
    if (is_lock) lck_q[i].push_back(e);
    else         clk_q[i].push_back(e);
  endtask

  // Reference model: lock after L sampled edges, first output rise one period later
  // (half a period later for odd D), high D*HP, period 2*D*HP.
  task automatic gen(input int i, input longint t_rel, input longint t_stop, input bit by_reset);
    longint d, l, tp, tl, rise, fall;
    bit hi;
    d  = longint'(DIV_T[i]);
    l  = longint'(LCK_T[i]);
    hi = 1'b0;
    tp = HP + 2 * HP * ((t_rel - HP) / (2 * HP) + 1);
    tl = tp + (l - 1) * 2 * HP;
    if (tl < t_stop) begin
      push_ev(i, 1'b1, 1'b1, tl);
      rise = tl + 2 * HP + (((d % 2) == 1) ? HP : 0);
      while (rise < t_stop) begin
        push_ev(i, 1'b0, 1'b1, rise);
        hi   = 1'b1;
        fall = rise + d * HP;
        if (fall >= t_stop) break;
        push_ev(i, 1'b0, 1'b0, fall);
        hi   = 1'b0;
        rise = rise + 2 * d * HP;
      end
    end
    if (by_reset) begin
      if (hi) push_ev(i, 1'b0, 1'b0, t_stop);
      if (tl < t_stop) push_ev(i, 1'b1, 1'b0, t_stop);
    end
  endtask

  task automatic sched(input longint t, input int i, input logic v);
    int k;
    k = 0;
    while ((k < sch_t.size()) && (sch_t[k] <= t)) k++;
    sch_t.insert(k, t);
    sch_i.insert(k, i);
    sch_v.insert(k, v);
  endtask

  task automatic check_ev(input int i, input bit is_lock, input logic v);
    ev_t    e;
    longint now;
    int     sz;
    now = longint'($time);
    n_tests++;
    sz = is_lock ? lck_q[i].size() : clk_q[i].size();
    if (sz == 0) begin
      n_fail++;
      $display("FAIL dut%0d %s: unexpected change to %0b at t=%0d (no edge expected)",
               i, is_lock ? "LOCKED" : "CLK_OUT1", v, now);
      return;
    end
    e = is_lock ? lck_q[i].pop_front() : clk_q[i].pop_front();
    if ((e.val !== v) || (e.t != now)) begin
      n_fail++;
      $display("FAIL dut%0d %s edge: got %0b at t=%0d, expected %0b at t=%0d",
               i, is_lock ? "LOCKED" : "CLK_OUT1", v, now, e.val, e.t);
    end
  endtask

  task automatic chk_level(input string name, input int i, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0b, expected %0b", name, i, got, exp);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    divisor_dcm #(
      .DIVIDE     (DIV_T[g]),
      .LOCK_CYCLES(LCK_T[g])
    ) u_dut (
      .CLK_IN1 (clk),
      .RESET   (rst[g]),
      .CLK_OUT1(dout[g]),
      .LOCKED  (dlock[g])
    );

    always @(dout[g])  if (!done && ($time > 0)) check_ev(g, 1'b0, dout[g]);
    always @(dlock[g]) if (!done && ($time > 0)) check_ev(g, 1'b1, dlock[g]);
  end

  // Level checks while every instance is still in reset (sampled on falling edges).
  initial begin
    #60;
    for (int i = 0; i < NDUT; i++) begin
      chk_level("reset CLK_OUT1 @60", i, dout[i], 1'b0);
      chk_level("reset LOCKED @60", i, dlock[i], 1'b0);
    end
    #20;
    for (int i = 0; i < NDUT; i++) begin
      chk_level("reset CLK_OUT1 @80", i, dout[i], 1'b0);
      chk_level("reset LOCKED @80", i, dlock[i], 1'b0);
    end
  end

  initial begin
    longint rel, s, r2;
    rst = '0;

    // Instances 0..4 released at 100; instance 5 stays in reset for the whole run.
    for (int i = 0; i < 5; i++) sched(100, i, 1'b1);
    for (int i = 1; i < 4; i++) gen(i, 100, T_END, 1'b0);

    // Instance 0: 15-unit reset pulse in the middle of a CLK_OUT1 high phase.
    gen(0, 100, 1232, 1'b1);
    sched(1232, 0, 1'b0);
    sched(1247, 0, 1'b1);
    gen(0, 1247, T_END, 1'b0);

    // Instance 4: random reset pulses, never aligned to a clock edge.
    rel = 100;
    for (int p = 0; p < 4; p++) begin
      s  = (rel / 10 + 30 + longint'($urandom_range(0, 300))) * 10 + longint'($urandom_range(1, 9));
      r2 = (s / 10 + 1 + longint'($urandom_range(0, 3))) * 10 + longint'($urandom_range(1, 9));
      gen(4, rel, s, 1'b1);
      sched(s, 4, 1'b0);
      sched(r2, 4, 1'b1);
      rel = r2;
    end
    gen(4, rel, T_END, 1'b0);

    for (int k = 0; k < sch_t.size(); k++) begin
      if (sch_t[k] > longint'($time)) #(sch_t[k] - longint'($time));
      rst[sch_i[k]] = sch_v[k];
    end
    #(T_END - longint'($time));
    done = 1'b1;

    chk_level("held-reset CLK_OUT1 end", 5, dout[5], 1'b0);
    chk_level("held-reset LOCKED end", 5, dlock[5], 1'b0);
    for (int i = 0; i < 5; i++) chk_level("LOCKED at end", i, dlock[i], 1'b1);
    for (int i = 0; i < NDUT; i++) begin
      n_tests++;
      if (clk_q[i].size() != 0) begin
        n_fail++;
        $display("FAIL dut%0d CLK_OUT1 missing edges: %0d pending, expected 0 (next t=%0d)",
                 i, clk_q[i].size(), clk_q[i][0].t);
      end
      n_tests++;
      if (lck_q[i].size() != 0) begin
        n_fail++;
        $display("FAIL dut%0d LOCKED missing edges: %0d pending, expected 0 (next t=%0d)",
                 i, lck_q[i].size(), lck_q[i][0].t);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
